// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and default constants for the button
//                conditioner: per-channel state encoding, default parameter
//                values and the counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_N_BTN           = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_EN       = 0;
  localparam int DEF_REPEAT_DELAY    = 8;
  localparam int DEF_REPEAT_PERIOD   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One width serves both the debounce and the repeat counter.
  function automatic int cnt_width(input int deb, input int rdly, input int rper);
    return $clog2(max3(deb, rdly, rper) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button channel: 2-flop synchroniser, debounce FSM,
//                optional auto-repeat, registered outputs.
//  Ports       : clk, rst      - system clock, synchronous active-high reset
//                i_btn_n       - raw asynchronous active-low button
//                o_level       - debounced level, 1 = pressed
//                o_press       - one-cycle strobe on accepted press / repeat
//                o_release     - one-cycle strobe on accepted release
//  Revision    : 1.0  initial release
// ============================================================================
module btn_channel import btn_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser (idles at 1 = not pressed)
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic w_pressed;

  // FSM, debounce counter and registered outputs
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             w_fsm_press;
  logic             rpt_fire;

  always_comb begin
    sync1_d = i_btn_n;
    sync2_d = sync1_q;
  end

  assign w_pressed = ~sync2_q;
  assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    w_fsm_press = 1'b0;
    release_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (w_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == c_deb_last) begin
          state_d     = HELD;
          cnt_d       = '0;
          level_d     = 1'b1;
          w_fsm_press = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == c_deb_last) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Repeat fires only on cycles where the FSM both is and stays in HELD, so a
  // pending repeat is dropped on the edge that moves to RELEASE_WAIT.
  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam logic [CNT_W-1:0] c_rdly_last = CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] c_rper_last = CNT_W'(REPEAT_PERIOD - 1);

      logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d, w_rpt_target;
      // 1 while waiting out the initial delay, 0 once in periodic mode
      logic             rpt_first_q, rpt_first_d;

      always_comb begin
        rpt_cnt_d    = rpt_cnt_q;
        rpt_first_d  = rpt_first_q;
        rpt_fire     = 1'b0;
        w_rpt_target = rpt_first_q ? c_rdly_last : c_rper_last;
        if ((state_q == HELD) && (state_d == HELD)) begin
          if (rpt_cnt_q == w_rpt_target) begin
            rpt_fire    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else if (rpt_cnt_q != {CNT_W{1'b1}}) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end else begin
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
        end else begin
          rpt_cnt_q   <= rpt_cnt_d;
          rpt_first_q <= rpt_first_d;
        end
      end
    end else begin : g_no_repeat
      assign rpt_fire = 1'b0;
    end
  endgenerate

  assign press_d = w_fsm_press | rpt_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : N_BTN independent button conditioning channels (synchronise,
//                debounce, optional auto-repeat) with registered outputs.
//  Ports       : Clk           - system clock
//                Reset         - synchronous active-high reset
//                btn_n         - raw active-low buttons, 0 = pressed
//                btn_level     - debounced levels, 1 = pressed
//                press_pulse   - one-cycle strobes on press / auto-repeat
//                release_pulse - one-cycle strobes on release
//  Revision    : 1.0  initial release
// ============================================================================
module button_conditioner import btn_pkg::*; #(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (REPEAT_EN),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
        .clk       (Clk),
        .rst       (Reset),
        .i_btn_n   (btn_n[i]),
        .o_level   (btn_level[i]),
        .o_press   (press_pulse[i]),
        .o_release (release_pulse[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench for button_conditioner. Two instances
//                (auto-repeat off / on) share the same stimulus; a run-length
//                reference model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int LAT = 2 + D;   // edge of first sample -> pulse cycle

  logic         Clk   = 1'b0;
  logic         Reset = 1'b1;
  logic [N-1:0] btn_n = '1;
  logic [N-1:0] lvl0, prs0, rel0;   // repeat disabled
  logic [N-1:0] lvl1, prs1, rel1;   // repeat enabled

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: [instance][channel]
  logic [N-1:0] dl1 = '1, dl2 = '1;
  logic [N-1:0] m_level [2];
  logic [N-1:0] m_press [2];
  logic [N-1:0] m_rel   [2];
  int           m_run   [2][N];
  int           m_t     [2][N];

  always #5 Clk = ~Clk;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_plain (
    .Clk(Clk), .Reset(Reset), .btn_n(btn_n),
    .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0)
  );

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_rep (
    .Clk(Clk), .Reset(Reset), .btn_n(btn_n),
    .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1)
  );

  // Advance one clock edge and update the model. A level change is accepted
  // once D+1 consecutive synchronised samples disagree with the current level;
  // samples reach the decision logic two edges after btn_n is captured.
  task automatic tick();
    logic [N-1:0] samp;
    logic         p;
    @(posedge Clk);
    cyc++;
    if (Reset) begin
      dl1 = '1;
      dl2 = '1;
      for (int i = 0; i < 2; i++) begin
        m_level[i] = '0; m_press[i] = '0; m_rel[i] = '0;
        for (int c = 0; c < N; c++) begin m_run[i][c] = 0; m_t[i][c] = 0; end
      end
    end else begin
      samp = dl2;
      dl2  = dl1;
      dl1  = btn_n;
      for (int i = 0; i < 2; i++) begin
        m_press[i] = '0;
        m_rel[i]   = '0;
        for (int c = 0; c < N; c++) begin
          p = ~samp[c];
          if (p != m_level[i][c]) begin
            m_run[i][c]++;
            m_t[i][c] = 0;
            if (m_run[i][c] == D + 1) begin
              m_level[i][c] = p;
              m_run[i][c]   = 0;
              if (p) m_press[i][c] = 1'b1;
              else   m_rel[i][c]   = 1'b1;
            end
          end else begin
            if (p && m_run[i][c] == 0) begin
              m_t[i][c]++;
              if (i == 1 && (m_t[i][c] == RD ||
                  (m_t[i][c] > RD && (m_t[i][c] - RD) % RP == 0)))
                m_press[i][c] = 1'b1;
            end else begin
              m_t[i][c] = 0;
            end
            m_run[i][c] = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      btn_n = N'($urandom);
      tick();
      checks++;
      if ({lvl0, prs0, rel0, lvl1, prs1, rel1} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: cycle %0d got %b expected all zero", cyc,
                 {lvl0, prs0, rel0, lvl1, prs1, rel1});
      end
    end
    btn_n = '1;
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({lvl0, prs0, rel0, lvl1, prs1, rel1} !== '0) begin
        failures++;
        $display("FAIL idle_outputs: cycle %0d got %b expected all zero", cyc,
                 {lvl0, prs0, rel0, lvl1, prs1, rel1});
      end
    end
  endtask

  task automatic test_press();
    int e, npulse, pcyc;
    npulse = 0; pcyc = -1;
    btn_n[0] = 1'b0;
    e = cyc + 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (prs0[0]) begin npulse++; pcyc = cyc; end
      checks++;
      if (lvl0[0] !== (cyc >= e + LAT)) begin
        failures++;
        $display("FAIL press_level: cycle %0d got %b expected %b", cyc, lvl0[0], cyc >= e + LAT);
      end
    end
    checks++;
    if (npulse !== 1 || pcyc !== e + LAT) begin
      failures++;
      $display("FAIL press_pulse: count %0d at cycle %0d, expected 1 at %0d", npulse, pcyc, e + LAT);
    end
  endtask

  task automatic test_bounce();
    logic pat [6];
    int   bad;
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      btn_n[1] = (k < 6) ? pat[k] : 1'b1;
      tick();
      if (prs0[1] || rel0[1] || lvl0[1] || prs1[1] || rel1[1] || lvl1[1]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bounce: %0d cycles with activity on channel 1, expected 0", bad);
    end
  endtask

  task automatic test_release();
    int r, nrel, rcyc, overlap;
    nrel = 0; rcyc = -1; overlap = 0;
    btn_n[0] = 1'b1;
    r = cyc + 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (rel0[0]) begin nrel++; rcyc = cyc; end
      if ((prs0 & rel0) != '0 || (prs1 & rel1) != '0) overlap++;
      checks++;
      if (lvl0[0] !== (cyc < r + LAT)) begin
        failures++;
        $display("FAIL release_level: cycle %0d got %b expected %b", cyc, lvl0[0], cyc < r + LAT);
      end
    end
    checks++;
    if (nrel !== 1 || rcyc !== r + LAT) begin
      failures++;
      $display("FAIL release_pulse: count %0d at cycle %0d, expected 1 at %0d", nrel, rcyc, r + LAT);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL release_exclusive: %0d overlapping cycles, expected 0", overlap);
    end
  endtask

  task automatic test_repeat();
    int e, h, nplain;
    int got[$];
    int exp_q[$];
    do_reset(2);
    nplain = 0;
    btn_n[0] = 1'b0;
    e = cyc + 1;
    h = e + LAT;
    while (cyc < h + 29) begin
      tick();
      if (prs1[0]) got.push_back(cyc);
      if (prs0[0]) nplain++;
    end
    btn_n[0] = 1'b1;
    while (cyc < h + 50) begin
      tick();
      if (prs1[0]) got.push_back(cyc);
      if (prs0[0]) nplain++;
    end
    exp_q.push_back(h);
    for (int t = h + RD; t <= h + 28; t += RP) exp_q.push_back(t);
    checks++;
    if (got.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL repeat_count: got %0d pulses expected %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL repeat_time[%0d]: got cycle %0d expected %0d", i, got[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (nplain !== 1) begin
      failures++;
      $display("FAIL no_repeat_single: got %0d pulses expected 1", nplain);
    end
  endtask

  task automatic test_reset_abort();
    int e, f, npulse, pcyc;
    do_reset(2);
    npulse = 0; pcyc = -1;
    btn_n[0] = 1'b0;
    e = cyc + 1;
    while (cyc < e + 3) begin
      tick();
      if (prs0[0]) begin npulse++; pcyc = cyc; end
    end
    Reset = 1'b1;
    tick();
    if (prs0[0]) begin npulse++; pcyc = cyc; end
    Reset = 1'b0;
    f = cyc + 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (prs0[0]) begin npulse++; pcyc = cyc; end
    end
    checks++;
    if (npulse !== 1 || pcyc !== f + LAT) begin
      failures++;
      $display("FAIL reset_abort: count %0d at cycle %0d, expected 1 at %0d", npulse, pcyc, f + LAT);
    end
    btn_n = '1;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int e, nboth, npart, bcyc;
    do_reset(2);
    nboth = 0; npart = 0; bcyc = -1;
    btn_n = '0;
    e = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (prs0 == 2'b11) begin nboth++; bcyc = cyc; end
      else if (prs0 != 2'b00) npart++;
    end
    checks++;
    if (nboth !== 1 || npart !== 0 || bcyc !== e + LAT) begin
      failures++;
      $display("FAIL simultaneous: both=%0d partial=%0d at cycle %0d, expected 1/0 at %0d",
               nboth, npart, bcyc, e + LAT);
    end
    btn_n = '1;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int remain [N];
    do_reset(2);
    for (int c = 0; c < N; c++) remain[c] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          btn_n[c] = ~btn_n[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                  : int'($urandom_range(1, 8));
        end
      end
      Reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if ({lvl0, prs0, rel0} !== {m_level[0], m_press[0], m_rel[0]}) begin
        failures++;
        $display("FAIL random_plain: cycle %0d got lvl/prs/rel %b/%b/%b expected %b/%b/%b",
                 cyc, lvl0, prs0, rel0, m_level[0], m_press[0], m_rel[0]);
      end
      checks++;
      if ({lvl1, prs1, rel1} !== {m_level[1], m_press[1], m_rel[1]}) begin
        failures++;
        $display("FAIL random_repeat: cycle %0d got lvl/prs/rel %b/%b/%b expected %b/%b/%b",
                 cyc, lvl1, prs1, rel1, m_level[1], m_press[1], m_rel[1]);
      end
      checks++;
      if ((prs0 & rel0) != '0 || (prs1 & rel1) != '0) begin
        failures++;
        $display("FAIL random_exclusive: cycle %0d prs0=%b rel0=%b prs1=%b rel1=%b expected no overlap",
                 cyc, prs0, rel0, prs1, rel1);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_repeat();
    test_reset_abort();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 2: number of independent button channels (for example Run and Continue); range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples required to accept a level change; range 1..2^20.
REQ-003 Parameter REPEAT_EN, default 0: 1 enables auto-repeat press pulses while a button is held.
REQ-004 Parameter REPEAT_DELAY, default 8: cycles in HELD before the first repeat pulse; must be at least 1.
REQ-005 Parameter REPEAT_PERIOD, default 4: cycles between subsequent repeat pulses; must be at least 1.
REQ-006 Port Clk, input, 1: single system clock.
REQ-007 Port Reset, input, 1: synchronous, active-high reset.
REQ-008 Port btn_n, input, N_BTN: raw asynchronous active-low buttons; 0 means pressed.
REQ-009 Port btn_level, output, N_BTN: debounced level; 1 means pressed.
REQ-010 Port press_pulse, output, N_BTN: one-cycle strobe on an accepted press or on an auto-repeat tick.
REQ-011 Port release_pulse, output, N_BTN: one-cycle strobe on an accepted release.

Function
REQ-012 Each channel SHALL pass btn_n through a 2-flop synchroniser before any other logic.
REQ-013 Each channel SHALL contain one FSM with states RELEASED, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 RELEASED SHALL go to PRESS_WAIT when the synchronised input is 0; the debounce counter is cleared on entry.
REQ-015 PRESS_WAIT SHALL return to RELEASED if the synchronised input is 1 on any cycle; no pulse is issued and the counter is cleared.
REQ-016 PRESS_WAIT SHALL go to HELD when the counter reaches DEBOUNCE_CYCLES-1 and the input is still 0; on that edge btn_level is set to 1 and press_pulse is high for exactly the next cycle.
REQ-017 Press latency SHALL be: a stable press sampled first at edge E gives press_pulse high in cycle E+2+DEBOUNCE_CYCLES, with ±1 cycle allowed for synchroniser metastability only.
REQ-018 HELD to RELEASE_WAIT and RELEASE_WAIT to RELEASED SHALL mirror REQ-014 to REQ-016 with the input polarity inverted; on acceptance btn_level clears and release_pulse is high for one cycle.
REQ-019 If REPEAT_EN=1, a repeat counter SHALL run in HELD; press_pulse fires REPEAT_DELAY cycles after the HELD entry pulse, then every REPEAT_PERIOD cycles.
REQ-020 The repeat counter SHALL reset on leaving HELD, and no repeat pulse may fire in RELEASE_WAIT.
REQ-021 If REPEAT_EN=0, the repeat logic SHALL be absent and press_pulse fires once per accepted press.
REQ-022 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), and counters saturate without wrapping.
REQ-023 press_pulse and release_pulse on the same channel SHALL be mutually exclusive in every cycle.
REQ-024 Channels SHALL be fully independent: simultaneous presses on several channels give pulses in the same cycle.
REQ-025 All outputs SHALL be registered, with no combinational path from btn_n to any output.

Reset
REQ-026 While Reset=1, the synchroniser flops SHALL load 1, the FSM goes to RELEASED, counters go to 0, and btn_level, press_pulse and release_pulse are 0.
REQ-027 Reset applied mid-debounce or mid-hold SHALL abort without issuing any pulse.
REQ-028 A button held across reset deassertion SHALL be treated as a new press, giving press_pulse after the REQ-017 latency counted from the first post-reset edge.

Structure
REQ-029 Package btn_pkg SHALL hold the btn_state_t enum (RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT) and the default parameter constants.
REQ-030 Sub-module btn_channel SHALL implement one channel: synchroniser, FSM and counters; button_conditioner instantiates N_BTN copies with a generate loop.

Verification
REQ-031 N_BTN=2, DEBOUNCE_CYCLES=4: hold btn_n[0]=0 from edge 10 -> one press_pulse[0] at cycle 16 and btn_level[0]=1 from cycle 16.
REQ-032 Bounce on btn_n[1]: 0 for 2 cycles, 1 for 1, 0 for 2, then 1 -> no pulse, and btn_level[1] stays 0.
REQ-033 Release after a hold -> exactly one release_pulse 6 cycles after release; press_pulse is never asserted in the same cycle.
REQ-034 REPEAT_EN=1, DELAY=8, PERIOD=4, hold for 30 cycles after HELD -> press pulses at HELD+0, +8, +12, +16, +20, +24, +28 and none after release.
REQ-035 Reset=1 for 1 cycle in PRESS_WAIT while held -> no pulse from the aborted press, then press_pulse 6 cycles after Reset falls.
REQ-036 Both channels pressed on the same edge -> press_pulse=2'b11 in a single cycle.
